gray_conv_arbiter: RTL and testbench
====================================

// Module: gray_conv_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one binary-to-Gray conversion stage among N_REQ requesters.
//  - Accepts one binary word per grant.
//  - Converts it (G = B ^ (B >> 1)).
//  - Returns the Gray word with the requester ID over a valid/ready output handshake.
//  - Sits between multiple counter/pointer sources and the single converter datapath.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  WIDTH   4   binary/Gray word width in bits
//  IDW     2   requester ID width, = clog2(N_REQ)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  req        in   N_REQ        per-requester request level
//  bin_in     in   N_REQ*WIDTH  packed binary words; requester i uses bits [i*WIDTH +: WIDTH]
//  gnt        out  N_REQ        one-hot, 1-cycle pulse: requester's word has been captured
//  gray_out   out  WIDTH        converted Gray word (registered)
//  gray_id    out  IDW          index of the requester that owns gray_out
//  gray_valid out  1            gray_out/gray_id valid
//  out_ready  in   1            downstream accepts when gray_valid & out_ready
//  busy       out  1            high in any state other than IDLE
//  xfer_cnt   out  8            completed-transfer counter, wraps 255->0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; gnt, gray_out, gray_id, gray_valid, busy and xfer_cnt are all 0.
//   - RR pointer last=N_REQ-1, so requester 0 has highest priority first.
//   - Reset mid-transaction discards the captured word; no gnt or valid is emitted.
//  FSM states:
//   - IDLE: if |req, pick the winner by RR search from last+1 upward, modulo N_REQ.
//     At the same edge: capture bin_in[winner] into op_reg, set last=winner, go to CONV.
//     Otherwise stay in IDLE.
//   - CONV (1 cycle): gnt[winner]=1. gray_out <= op_reg ^ (op_reg>>1), gray_id <= winner. Go to OUT.
//   - OUT: gray_valid=1. gray_out and gray_id are held stable until out_ready=1.
//     On the accepting edge: xfer_cnt++, then go to IDLE.
//  Timing:
//   - Latency from a req sampled in cycle T: gnt at T+1, gray_valid at T+2 (if out_ready=1).
//   - Minimum spacing between grants is 3 cycles.
//  Conversion: MSB is passed through; each lower bit is the XOR of adjacent input bits. Purely bitwise, no carries.
//  Requester rules:
//   - Hold req and bin_in until gnt is seen.
//   - gnt means the word was captured at the previous edge, so bin_in may change in the gnt cycle.
//   - A req still high after gnt is treated as a new request.
//   - req changes while not in IDLE are ignored. A req dropped before capture is never granted.
//  Simultaneous requests: exactly one gnt per transaction, and no requester is skipped while requesting.
//  Back-pressure: out_ready low stalls in OUT indefinitely. No new grant is issued during the stall.
//  busy = (state != IDLE). gnt and gray_valid are never high together.
// TESTING
//  1. Single req[0], bin=4'b1011, out_ready=1 -> gnt=0001 at T+1; gray_out=4'b1110, id=0, valid at T+2; xfer_cnt=1.
//  2. req=4'b1111 held, words 0000/0111/1111/1000, out_ready=1 -> grants in order 0,1,2,3,0.
//     Outputs are 0000, 0100, 1000, 1100.
//  3. Stall: req[2]=1 with bin=4'b0110, out_ready=0 for 5 cycles -> gray_out=4'b0101, id=2 held stable;
//     no gnt issued; accepted on the first out_ready=1 cycle.
//  4. Fairness: grant to 1 completes, then req=4'b0011 -> next grant goes to 0 (not 1), then 1.
//  5. Reset in CONV: rst_n low for 1 cycle -> all outputs 0 immediately; the next req[3] is granted first
//     because RR restarts at requester 0's priority and 0..2 are idle.
//  6. Wrap: 256 single transfers -> xfer_cnt returns to 0; exhaustive 16 binary inputs match the G=B^(B>>1) table.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray conversion stage among N_REQ requesters.
// Each transaction runs IDLE (capture) -> CONV (grant, convert) -> OUT (hold until accepted).
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] bin_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       gray_out,
  output logic [IDW-1:0]         gray_id,
  output logic                   gray_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [7:0]             xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_last;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_gray;
  logic [IDW-1:0]   r_gray_id;
  logic [7:0]       r_xfer_cnt;
  logic             w_found;
  logic [IDW-1:0]   w_win;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Round-robin search starting just above the last winner, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_found && req[idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_CONV;
      S_CONV:  w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= IDW'(N_REQ - 1);
      r_op       <= '0;
      r_gray     <= '0;
      r_gray_id  <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op   <= bin_in[int'(w_win)*WIDTH +: WIDTH];
            r_last <= w_win;
          end
        end
        S_CONV: begin
          r_gray    <= bin2gray(r_op);
          r_gray_id <= r_last;
        end
        S_OUT: begin
          if (out_ready) r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Grant and valid decode from state alone, so they can never overlap.
  assign gnt        = (r_state == S_CONV) ? (N_REQ'(1) << r_last) : '0;
  assign gray_valid = (r_state == S_OUT);
  assign busy       = (r_state != S_IDLE);
  assign gray_out   = r_gray;
  assign gray_id    = r_gray_id;
  assign xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: transaction-level reference model plus directed scenarios.
module tb_gray_conv_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int I = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] bin_in;
  logic [N-1:0]   gnt;
  logic [W-1:0]   gray_out;
  logic [I-1:0]   gray_id;
  logic           gray_valid;
  logic           out_ready;
  logic           busy;
  logic [7:0]     xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  gray_conv_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(I)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in), .gnt(gnt),
    .gray_out(gray_out), .gray_id(gray_id), .gray_valid(gray_valid),
    .out_ready(out_ready), .busy(busy), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Transaction model: a transaction is captured at edge m_e0, granted in the
  // cycle after it, presented from the cycle after that until an accepting edge.
  int       cyc = 0;
  bit       m_active = 0;
  int       m_e0 = 0;
  int       m_id = 0;
  int       m_gray = 0;
  int       m_last = N - 1;
  int       m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_last   = N - 1;
      m_cnt    = 0;
    end else begin
      cyc++;
      if (m_active) begin
        if (cyc >= m_e0 + 2 && out_ready) begin
          m_cnt    = (m_cnt + 1) % 256;
          m_active = 0;
        end
      end else if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (!m_active && req[idx]) begin
            int b;
            b        = int'(bin_in[idx*W +: W]);
            m_active = 1;
            m_id     = idx;
            m_gray   = b ^ (b / 2);
          end
        end
        m_e0   = cyc;
        m_last = m_id;
      end
    end
  end

  // Per-cycle comparison against the model, plus logs of grants and delivered words.
  int   g_q[$];
  int   a_q[$];
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt;
    e_gnt = (m_active && cyc == m_e0) ? N'(1 << m_id) : '0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gray_valid", 32'(gray_valid), 32'(m_active && cyc >= m_e0 + 1));
    chk("busy", 32'(busy), 32'(m_active));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    chk("gnt_and_valid", 32'(|gnt && gray_valid), 32'(0));
    if (gray_valid) begin
      chk("gray_out", 32'(gray_out), 32'(m_gray));
      chk("gray_id", 32'(gray_id), 32'(m_id));
    end
    for (int i = 0; i < N; i++) if (gnt[i]) g_q.push_back(i);
    if (gray_valid && !prev_valid) a_q.push_back(int'(gray_out));
    prev_valid = gray_valid;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) timeout_fail(name);
  endtask

  task automatic do_xfer(input int id, input logic [W-1:0] word);
    int n = 0;
    req = N'(1 << id);
    bin_in[id*W +: W] = word;
    do begin
      tick();
      n++;
    end while (gnt == 0 && n < 8);
    if (gnt == 0) timeout_fail("xfer_gnt");
    req = '0;
    wait_idle("xfer_done");
  endtask

  int gray_tbl[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int exp_g2[5]    = '{0, 1, 2, 3, 0};
  int exp_a2[5]    = '{4'b0000, 4'b0100, 4'b1000, 4'b1100, 4'b0000};

  initial begin
    int n;
    rst_n = 1'b0; req = '0; bin_in = '0; out_ready = 1'b1;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(gray_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gray", 32'(gray_out), 0);
    chk("rst_cnt", 32'(xfer_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 0
    req = 4'b0001; bin_in[3:0] = 4'b1011;
    tick();
    chk("t1_gnt", 32'(gnt), 32'(4'b0001));
    req = '0; bin_in = '0;
    tick();
    chk("t1_valid", 32'(gray_valid), 1);
    chk("t1_gray", 32'(gray_out), 32'(4'b1110));
    chk("t1_id", 32'(gray_id), 0);
    tick();
    chk("t1_cnt", 32'(xfer_cnt), 1);
    chk("t1_busy", 32'(busy), 0);

    // All four requesting: round-robin order 0,1,2,3,0
    pulse_reset();
    bin_in = {4'b1000, 4'b1111, 4'b0111, 4'b0000};
    g_q.delete(); a_q.delete();
    req = 4'b1111;
    n = 0;
    while (g_q.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    req = '0;
    wait_idle("t2_done");
    chk("t2_ngnt", 32'(g_q.size()), 5);
    chk("t2_nout", 32'(a_q.size()), 5);
    for (int i = 0; i < 5 && i < g_q.size(); i++) chk("t2_order", 32'(g_q[i]), 32'(exp_g2[i]));
    for (int i = 0; i < 5 && i < a_q.size(); i++) chk("t2_gray", 32'(a_q[i]), 32'(exp_a2[i]));

    // Back-pressure stall on requester 2 while others request
    tick();
    out_ready = 1'b0;
    req = 4'b0100; bin_in[11:8] = 4'b0110;
    tick();
    chk("t3_gnt", 32'(gnt), 32'(4'b0100));
    req = 4'b1011;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(gray_valid), 1);
      chk("t3_hold_gray", 32'(gray_out), 32'(4'b0101));
      chk("t3_hold_id", 32'(gray_id), 2);
      chk("t3_no_gnt", 32'(gnt), 0);
      tick();
    end
    out_ready = 1'b1; req = '0;
    tick();
    chk("t3_accepted", 32'(gray_valid), 0);

    // Fairness: after 1 completes, 0 wins before 1
    do_xfer(1, 4'b0101);
    g_q.delete();
    bin_in[3:0] = 4'b0001; bin_in[7:4] = 4'b0010;
    req = 4'b0011;
    n = 0;
    while (g_q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    req = '0;
    wait_idle("t4_done");
    chk("t4_ngnt", 32'(g_q.size()), 2);
    if (g_q.size() >= 2) begin
      chk("t4_first", 32'(g_q[0]), 0);
      chk("t4_second", 32'(g_q[1]), 1);
    end

    // Reset while in CONV discards the captured word
    tick();
    req = 4'b0001; bin_in[3:0] = 4'b1010;
    tick();
    chk("t5_in_conv", 32'(gnt), 32'(4'b0001));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_valid", 32'(gray_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_gray", 32'(gray_out), 0);
    chk("t5_rst_cnt", 32'(xfer_cnt), 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    g_q.delete(); a_q.delete();
    do_xfer(3, 4'b1001);
    chk("t5_ngnt", 32'(g_q.size()), 1);
    chk("t5_nout", 32'(a_q.size()), 1);
    if (g_q.size() >= 1) chk("t5_id", 32'(g_q[0]), 3);
    if (a_q.size() >= 1) chk("t5_gray", 32'(a_q[0]), 32'(4'b1101));

    // 256 transfers: counter wrap and exhaustive conversion table
    pulse_reset();
    a_q.delete();
    for (int k = 0; k < 256; k++) begin
      do_xfer(k % N, W'(k % 16));
      if (k == 15) begin
        chk("t6_n16", 32'(a_q.size()), 16);
        for (int j = 0; j < 16 && j < a_q.size(); j++) chk("t6_table", 32'(a_q[j]), 32'(gray_tbl[j]));
      end
      if (k == 127) chk("t6_cnt_mid", 32'(xfer_cnt), 128);
    end
    chk("t6_wrap", 32'(xfer_cnt), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
